ts_sync_switch: RTL and testbench

TS_SYNC_SWITCH -- requirements
Module: ts_sync_switch

---
 rtl/ts_sync_switch.sv | 227 ++++++++++++++++++++++
 tb/tb_ts_sync_switch.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ts_sync_switch.sv
// ts_sync_switch: selects one of N_CH MPEG transport-stream byte lanes and
// forwards it one cycle later, only ever on whole-packet boundaries.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   en         block enable; low forces IDLE and zero outputs
//   sel        requested channel (ignored while out of range)
//   data_in    N_CH byte lanes, channel k at [k*DATA_W +: DATA_W]
//   valid_in   per-channel byte strobe
//   sync_in    per-channel packet-start flag (qualified by valid_in)
//   data_out   forwarded byte (zero when nothing forwarded)
//   valid_out  forwarded byte valid
//   sync_out   forwarded byte is a packet start
//   active_ch  channel currently being forwarded / hunted
//   locked     high while aligned to a packet stream (PASS)
//   sel_err    combinational: sel >= N_CH
//   sync_err   one-cycle pulse on loss of packet alignment

// Per-lane gate: a lane contributes its byte only when it is the active
// channel, so the lanes can simply be OR-reduced into one byte.
module ts_sync_lane #(
  parameter int SEL_W  = 2,
  parameter int DATA_W = 8,
  parameter int LANE   = 0
) (
  input  logic [SEL_W-1:0]  active_ch,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic              sync,
  output logic [DATA_W-1:0] data_m,
  output logic              valid_m,
  output logic              sync_m
);
  logic hit;
  assign hit     = (active_ch == SEL_W'(LANE));
  assign data_m  = hit ? data : '0;
  assign valid_m = hit & valid;
  assign sync_m  = hit & valid & sync;
endmodule

module ts_sync_switch #(
  parameter int N_CH    = 4,
  parameter int SEL_W   = 2,
  parameter int DATA_W  = 8,
  parameter int PKT_LEN = 188
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [SEL_W-1:0]         sel,
  input  logic [N_CH*DATA_W-1:0]   data_in,
  input  logic [N_CH-1:0]          valid_in,
  input  logic [N_CH-1:0]          sync_in,
  output logic [DATA_W-1:0]        data_out,
  output logic                     valid_out,
  output logic                     sync_out,
  output logic [SEL_W-1:0]         active_ch,
  output logic                     locked,
  output logic                     sel_err,
  output logic                     sync_err
);

  localparam int                CNT_W  = $clog2(PKT_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST   = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0]  ONE    = CNT_W'(1);
  // One extra bit so the range check never degenerates into a constant.
  localparam logic [SEL_W:0]    N_CH_C = (SEL_W+1)'(N_CH);

  typedef enum logic [1:0] {IDLE, WAIT_SYNC, PASS} state_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              sync;
  } beat_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [SEL_W-1:0]  active_ch_q, active_ch_d;
  logic [SEL_W-1:0]  target_q, target;
  beat_t             out_q, out_d;
  logic              locked_q, locked_d;
  logic              sync_err_q, sync_err_d;
  logic              sel_ok, fwd;
  beat_t             cur;

  // ---------------------------------------------------------------------------
  // Channel select
  // ---------------------------------------------------------------------------
  assign sel_ok  = ({1'b0, sel} < N_CH_C);
  assign sel_err = ~sel_ok;
  // An out-of-range request leaves the previous target in place.
  assign target  = sel_ok ? sel : target_q;

  // ---------------------------------------------------------------------------
  // Lane gating and reduction onto the active channel
  // ---------------------------------------------------------------------------
  logic [N_CH-1:0][DATA_W-1:0] lane_data;
  logic [N_CH-1:0]             lane_valid;
  logic [N_CH-1:0]             lane_sync;

  for (genvar g = 0; g < N_CH; g++) begin : g_lane
    ts_sync_lane #(
      .SEL_W  (SEL_W),
      .DATA_W (DATA_W),
      .LANE   (g)
    ) u_lane (
      .active_ch (active_ch_q),
      .data      (data_in[g*DATA_W +: DATA_W]),
      .valid     (valid_in[g]),
      .sync      (sync_in[g]),
      .data_m    (lane_data[g]),
      .valid_m   (lane_valid[g]),
      .sync_m    (lane_sync[g])
    );
  end

  always_comb begin
    cur.data = '0;
    for (int k = 0; k < N_CH; k++) cur.data = cur.data | lane_data[k];
    cur.valid = |lane_valid;
    cur.sync  = |lane_sync;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  assign cnt_inc = (cnt_q == LAST) ? ONE : cnt_q + ONE;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_ch_d = active_ch_q;
    fwd         = 1'b0;
    sync_err_d  = 1'b0;

    if (!en) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          active_ch_d = target;
          cnt_d       = '0;
          state_d     = WAIT_SYNC;
        end

        WAIT_SYNC: begin
          active_ch_d = target;
          // Only lock when the hunted channel is still the wanted one, so a
          // sync seen on a channel being abandoned cannot start a packet.
          if (target == active_ch_q && cur.valid && cur.sync) begin
            fwd     = 1'b1;
            cnt_d   = ONE;
            state_d = PASS;
          end
        end

        PASS: begin
          if (cnt_q == LAST && target != active_ch_q) begin
            // Sitting exactly on a packet boundary with a new request.
            active_ch_d = target;
            cnt_d       = '0;
            state_d     = WAIT_SYNC;
          end else if (cur.valid) begin
            if (cur.sync != (cnt_q == LAST)) begin
              // Sync where none belongs, or missing where one must be.
              sync_err_d  = 1'b1;
              active_ch_d = target;
              cnt_d       = '0;
              state_d     = WAIT_SYNC;
            end else begin
              fwd   = 1'b1;
              cnt_d = cnt_inc;
              // Last byte of the packet just went out: honour a pending
              // switch now so no partial packet is ever emitted.
              if (cnt_inc == LAST && target != active_ch_q) begin
                active_ch_d = target;
                cnt_d       = '0;
                state_d     = WAIT_SYNC;
              end
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end

    out_d.valid = fwd;
    out_d.sync  = fwd & cur.sync;
    out_d.data  = fwd ? cur.data : '0;
    locked_d    = (state_d == PASS);
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      active_ch_q <= '0;
      target_q    <= '0;
      out_q       <= '0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_ch_q <= active_ch_d;
      target_q    <= target;
      out_q       <= out_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign data_out  = out_q.data;
  assign valid_out = out_q.valid;
  assign sync_out  = out_q.sync;
  assign active_ch = active_ch_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_ts_sync_switch.sv
// Directed bench for ts_sync_switch (N_CH=3, 188-byte packets). Each channel
// carries a free-running packet stream; byte value encodes channel and position.
module tb_ts_sync_switch;

  localparam int N = 3;
  localparam int L = 188;

  logic           clk, rst, en;
  logic [1:0]     sel;
  logic [N*8-1:0] data_in;
  logic [N-1:0]   valid_in, sync_in;
  logic [7:0]     data_out;
  logic           valid_out, sync_out, locked, sel_err, sync_err;
  logic [1:0]     active_ch;

  ts_sync_switch #(.N_CH(N), .SEL_W(2), .DATA_W(8), .PKT_LEN(L)) dut (
    .clk(clk), .rst(rst), .en(en), .sel(sel), .data_in(data_in),
    .valid_in(valid_in), .sync_in(sync_in), .data_out(data_out),
    .valid_out(valid_out), .sync_out(sync_out), .active_ch(active_ch),
    .locked(locked), .sel_err(sel_err), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int         pos [N];   // position (1..L) of the byte each channel presents next
  logic [N-1:0] vmask = '1, kill = '0, fsync = '0;
  int         errs = 0, checks = 0;

  function automatic logic [7:0] bval(input int k, input int p);
    int t;
    t = k * 64 + p;
    if (p == 1) return 8'h47;
    return t[7:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one byte per channel, clock it, sample #1 after the edge.
  task automatic step();
    for (int k = 0; k < N; k++) begin
      data_in[k*8 +: 8] = bval(k, pos[k]);
      valid_in[k]       = vmask[k];
      sync_in[k]        = ((pos[k] == 1) && !kill[k]) || fsync[k];
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < N; k++) if (vmask[k]) pos[k] = pos[k] % L + 1;
  endtask

  // Step until channel k is about to present position p; vc counts valid_out.
  task automatic advance_to(input int k, input int p, output int vc);
    int n;
    n = 0; vc = 0;
    while (pos[k] != p && n < 400) begin
      step();
      if (valid_out) vc++;
      n++;
    end
    if (n >= 400) chk("advance_timeout", n, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, mm, p, se, so;
    logic v;
    clk = 0; rst = 1; en = 0; sel = 0;
    data_in = '0; valid_in = '0; sync_in = '0;
    pos[0] = 1; pos[1] = 50; pos[2] = 100;

    // ---- reset state
    step(); step();
    chk("rst_data", data_out, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_sync", sync_out, 0);
    chk("rst_locked", locked, 0);
    chk("rst_syncerr", sync_err, 0);
    chk("rst_active", active_ch, 0);
    sel = 3; #1;
    chk("rst_selerr_comb", sel_err, 1);

    // ---- lock onto ch2 starting mid-packet
    rst = 0; en = 1; sel = 2; #1;
    chk("selerr_clear", sel_err, 0);
    advance_to(2, 1, vc);
    chk("pre_sync_silence", vc, 0);
    step();
    chk("lock_data", data_out, 8'h47);
    chk("lock_sync", sync_out, 1);
    chk("lock_valid", valid_out, 1);
    chk("lock_locked", locked, 1);
    chk("lock_active", active_ch, 2);
    mm = 0;
    for (int i = 2; i <= L; i++) begin
      p = pos[2];
      step();
      if (valid_out !== 1'b1 || data_out !== bval(2, p) || sync_out !== 1'b0) mm++;
    end
    chk("pkt_body", mm, 0);
    step();
    chk("pkt_reload_sync", sync_out, 1);
    chk("pkt_reload_data", data_out, 8'h47);

    // ---- valid gaps every other cycle on ch2, boundary still at byte 188
    mm = 0; se = 0; so = 0;
    for (int i = 0; i < 2 * L; i++) begin
      vmask[2] = (i % 2 == 0);
      v = vmask[2];
      p = pos[2];
      step();
      if (valid_out !== v) mm++;
      if (v && data_out !== bval(2, p)) mm++;
      if (!v && data_out !== 8'h00) mm++;
      if (sync_err) se++;
      if (sync_out) so++;
    end
    vmask = '1;
    chk("gap_stream", mm, 0);
    chk("gap_syncerr", se, 0);
    chk("gap_sync_count", so, 1);
    chk("gap_locked", locked, 1);

    // ---- switch ch2 -> ch0 requested after byte 50
    advance_to(2, 51, vc);
    sel = 0; pos[0] = 179;
    mm = 0;
    for (int i = 0; i <= 260; i++) begin
      step();
      if (i <= 137) begin
        if (valid_out !== 1'b1 || data_out !== bval(2, 51 + i)) mm++;
      end else if (i < 198) begin
        if (valid_out !== 1'b0 || data_out !== 8'h00) mm++;
      end else begin
        if (valid_out !== 1'b1 || data_out !== bval(0, i - 197)) mm++;
      end
      if (i == 150) begin
        chk("switch_gap_active", active_ch, 0);
        chk("switch_gap_locked", locked, 0);
      end
    end
    chk("switch_stream", mm, 0);
    chk("switch_locked", locked, 1);

    // ---- missing sync at byte 189 on ch0
    advance_to(0, L, vc);
    step();
    kill[0] = 1;
    step();
    kill[0] = 0;
    chk("miss_dropped", valid_out, 0);
    chk("miss_syncerr", sync_err, 1);
    chk("miss_locked", locked, 0);
    step();
    chk("miss_syncerr_pulse", sync_err, 0);
    advance_to(0, 1, vc);
    chk("miss_silence", vc, 0);
    step();
    chk("miss_relock", locked, 1);
    chk("miss_relock_sync", sync_out, 1);

    // ---- spurious sync mid-packet
    advance_to(0, 30, vc);
    fsync[0] = 1;
    step();
    fsync[0] = 0;
    chk("spur_dropped", valid_out, 0);
    chk("spur_syncerr", sync_err, 1);
    advance_to(0, 1, vc);
    step();
    chk("spur_relock", locked, 1);

    // ---- out-of-range select, then switch to ch1 at packet end
    advance_to(0, 40, vc);
    sel = 3; #1;
    chk("oor_selerr", sel_err, 1);
    step();
    chk("oor_active", active_ch, 0);
    chk("oor_data", data_out, bval(0, 40));
    advance_to(0, 60, vc);
    sel = 1; #1;
    chk("inr_selerr", sel_err, 0);
    advance_to(0, 100, vc);
    chk("pending_active", active_ch, 0);
    chk("pending_locked", locked, 1);
    advance_to(0, 1, vc);
    chk("last_byte_data", data_out, bval(0, L));
    chk("after_end_active", active_ch, 1);
    chk("after_end_locked", locked, 0);
    pos[1] = 180;
    advance_to(1, 1, vc);
    chk("ch1_silence", vc, 0);
    step();
    chk("ch1_lock_data", data_out, 8'h47);
    chk("ch1_lock_active", active_ch, 1);

    // ---- enable drop at byte 100, then re-enable
    advance_to(1, 100, vc);
    en = 0;
    step();
    chk("en0_valid", valid_out, 0);
    chk("en0_data", data_out, 0);
    chk("en0_locked", locked, 0);
    en = 1;
    step(); step();
    chk("en1_locked", locked, 0);
    chk("en1_valid", valid_out, 0);
    chk("en1_active", active_ch, 1);
    advance_to(1, 1, vc);
    chk("en1_silence", vc, 0);
    step();
    chk("en1_relock", locked, 1);

    // ---- reset at byte 20
    advance_to(1, 20, vc);
    rst = 1;
    step();
    chk("mrst_valid", valid_out, 0);
    chk("mrst_data", data_out, 0);
    chk("mrst_sync", sync_out, 0);
    chk("mrst_locked", locked, 0);
    chk("mrst_active", active_ch, 0);
    rst = 0;
    step();
    chk("mrst_resume_active", active_ch, 1);
    chk("mrst_resume_valid", valid_out, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
